rv32i_multicycle_datapath: RTL and testbench

Parametrised multi-cycle successor to the single-cycle RV32I datapath. It fetches and executes one instruction per 3–5 cycles through an internal state machine and talks to instruction and data memories over request/ready handshakes, so memories may take multiple cycles. Control signals still come from the external combinational decoder, driven from the latched instruction register `instr`. The block reuses `register_file_32bit`-style storage, `alu_32bit` and `extend`.

---
 rtl/rv32i_multicycle_datapath.sv | 234 +++++++++++++++++++++++
 tb/tb_rv32i_multicycle_datapath.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_multicycle_datapath.sv
// Multi-cycle RV32I datapath: FETCH/DECODE/EXECUTE/MEM/WB sequencer with req/ready memory ports.
// Define PERF_COUNTERS_EN to build the cycle and retired-instruction counters.
module rv32i_multicycle_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ALUSrc,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic [4:0]  ALUControl,
  output logic [31:0] instr,
  output logic [31:0] PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  localparam int        AW     = $clog2(NREGS);
  localparam logic [5:0] NREGS6 = 6'(NREGS);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] aluout_q, aluout_d;
  logic [31:0] mdr_q, mdr_d;
  logic        imem_req_q, imem_req_d;
  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] regs_q [NREGS];

  logic [31:0] rs1_val, rs2_val, alu_b, alu_y, pc_plus4, wb_data;
  logic        alu_z, rf_we, retire;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;

  function automatic logic [31:0] extend(input logic [31:0] i);
    logic [31:0] r;
    case (i[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: r = {{20{i[31]}}, i[31:20]};
      7'b0100011: r = {{20{i[31]}}, i[31:25], i[11:7]};
      7'b1100011: r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      7'b0110111, 7'b0010111: r = {i[31:12], 12'd0};
      7'b1101111: r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] alu(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0]        r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      5'd0:    r = a + b;
      5'd1:    r = a - b;
      5'd2:    r = a & b;
      5'd3:    r = a | b;
      5'd4:    r = a ^ b;
      5'd5:    r = a << b[4:0];
      5'd6:    r = a >> b[4:0];
      5'd7:    r = $unsigned(sa >>> b[4:0]);
      5'd8:    r = {31'd0, sa < sb};
      5'd9:    r = {31'd0, a < b};
      5'd10:   r = b;
      default: r = a + b;
    endcase
    return r;
  endfunction

  assign rs1_idx  = instr_q[19:15];
  assign rs2_idx  = instr_q[24:20];
  assign rd_idx   = instr_q[11:7];
  assign pc_plus4 = pc_q + 32'd4;
  assign alu_b    = ALUSrc ? imm_q : b_q;
  assign alu_y    = alu(ALUControl, a_q, alu_b);
  assign alu_z    = (alu_y == 32'd0);
  assign wb_data  = MemtoReg ? mdr_q : aluout_q;

  // x0 and any index beyond the implemented register count read as zero.
  always_comb begin
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    if (rs1_idx != 5'd0 && {1'b0, rs1_idx} < NREGS6) rs1_val = regs_q[rs1_idx[AW-1:0]];
    if (rs2_idx != 5'd0 && {1'b0, rs2_idx} < NREGS6) rs2_val = regs_q[rs2_idx[AW-1:0]];
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    retire   = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_req_q && imem_ready) begin
          instr_d = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        imm_d   = extend(instr_q);
        state_d = EXECUTE;
      end
      EXECUTE: begin
        aluout_d = alu_y;
        if (Branch) begin
          pc_d    = alu_z ? (pc_q + imm_q) : pc_plus4;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (MemRead || MemWrite) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        if (dmem_req_q && dmem_ready) begin
          if (dmem_we_q) begin
            pc_d    = pc_plus4;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            mdr_d   = dmem_rdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we   = RegWrite;
        pc_d    = pc_plus4;
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    // Requests are registered so they are low during reset and the cycle after release.
    imem_req_d = (state_d == FETCH);
    dmem_req_d = (state_d == MEM);
    dmem_we_d  = (state_d == MEM) && MemWrite;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      imm_q      <= 32'd0;
      aluout_q   <= 32'd0;
      mdr_q      <= 32'd0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      aluout_q   <= aluout_d;
      mdr_q      <= mdr_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
    end
  end

  // Write is gated by state, which async reset forces to FETCH, so a pending write is lost.
  always_ff @(posedge clk) begin
    if (rf_we && rd_idx != 5'd0 && {1'b0, rd_idx} < NREGS6)
      regs_q[rd_idx[AW-1:0]] <= wb_data;
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cycle_cnt     = 32'd0;
  assign instret_cnt   = 32'd0;
`endif

  assign instr      = instr_q;
  assign PC         = pc_q;
  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = aluout_q;
  assign dmem_wdata = b_q;

endmodule

// File: tb/tb_rv32i_multicycle_datapath.sv
// Directed bench for rv32i_multicycle_datapath: RV32I (u32) and RV32E (u16) copies run in lock-step.
module tb_rv32i_multicycle_datapath;

  localparam logic [31:0] RPC  = 32'h0000_0100;
  localparam logic [31:0] SPIN = 32'h0000_0063;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
  logic [4:0]  ALUControl;
  logic [31:0] instr, PC, imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [31:0] instr16, pc16, imem_addr16, dmem_addr16, dmem_wdata16, cyc16, ins16;
  logic        imem_req16, dmem_req16, dmem_we16;

  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  int          imem_wait = 0, dmem_wait = 0, icnt, dcnt, edges;
  int          n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  rv32i_multicycle_datapath #(.RESET_PC(RPC), .NREGS(32)) u32 (
    .clk(clk), .rst_n(rst_n), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUControl(ALUControl),
    .instr(instr), .PC(PC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt));

  rv32i_multicycle_datapath #(.RESET_PC(RPC), .NREGS(16)) u16 (
    .clk(clk), .rst_n(rst_n), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUControl(ALUControl),
    .instr(instr16), .PC(pc16), .imem_req(imem_req16), .imem_addr(imem_addr16),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .dmem_req(dmem_req16),
    .dmem_we(dmem_we16), .dmem_addr(dmem_addr16), .dmem_wdata(dmem_wdata16),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .cycle_cnt(cyc16), .instret_cnt(ins16));

  // External decoder (ALUControl: 0 = add, 1 = sub)
  always_comb begin
    ALUSrc = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; Branch = 1'b0; ALUControl = 5'd0;
    case (instr[6:0])
      7'b0010011: begin ALUSrc = 1'b1; RegWrite = 1'b1; end
      7'b0110011: begin RegWrite = 1'b1; ALUControl = instr[30] ? 5'd1 : 5'd0; end
      7'b0000011: begin ALUSrc = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; MemRead = 1'b1; end
      7'b0100011: begin ALUSrc = 1'b1; MemWrite = 1'b1; end
      7'b1100011: begin Branch = 1'b1; ALUControl = 5'd1; end
      default: ;
    endcase
  end

  assign imem_rdata = imem[imem_addr[9:2]];
  assign imem_ready = imem_req && (icnt == imem_wait);
  assign dmem_rdata = dmem[dmem_addr[7:2]];
  assign dmem_ready = dmem_req && (dcnt == dmem_wait);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt <= 0; dcnt <= 0; edges <= 0;
    end else begin
      edges <= edges + 1;
      icnt  <= (!imem_req || imem_ready) ? 0 : icnt + 1;
      dcnt  <= (!dmem_req || dmem_ready) ? 0 : dcnt + 1;
      if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr[7:2]] <= dmem_wdata;
    end
  end

  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[11:0], rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2, input int imm);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], rs2, rs1, 3'b000, v[4:1], v[11], 7'b1100011};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edges);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = SPIN;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    imem[addr[9:2]] = w;
  endtask

  task automatic reset_dut(input int iw, input int dw);
    rst_n = 1'b0;
    imem_wait = iw;
    dmem_wait = dw;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic run_to(input int e);
    int guard;
    guard = 0;
    while (edges < e && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("edge_reached", edges, e);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [4:0]  rs;
    logic [31:0] e32;
    logic [31:0] e16;
  } vec_t;

  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{"add_x1x1",  addi(1, 0, 5),     rtype(7'h00, 2, 1, 1), 5'd2,  32'd10,        32'd10};
    vt[1] = '{"sub_neg",   addi(1, 0, -3),    rtype(7'h20, 2, 0, 1), 5'd2,  32'd3,         32'd3};
    vt[2] = '{"x0_write",  addi(0, 0, 7),     addi(1, 0, 1),         5'd0,  32'd0,         32'd0};
    vt[3] = '{"imm_max",   addi(1, 0, 2047),  addi(2, 1, 2047),      5'd2,  32'd4094,      32'd4094};
    vt[4] = '{"imm_min",   addi(1, 0, -2048), rtype(7'h00, 3, 1, 1), 5'd3,  32'hFFFF_F000, 32'hFFFF_F000};
    vt[5] = '{"x17_e",     addi(17, 0, 1),    addi(1, 0, 0),         5'd17, 32'd1,         32'd0};
    vt[6] = '{"x15_edge",  addi(15, 0, 42),   addi(16, 0, 3),        5'd15, 32'd42,        32'd42};
    vt[7] = '{"chain_m1",  addi(5, 0, 9),     addi(5, 5, -10),       5'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF};

    #2 rst_n = 1'b0;

    // Reset values, first fetch, asynchronous reset in the middle of a fetch
    clear_imem();
    put(RPC, addi(1, 0, 5));
    put(RPC + 4, rtype(7'h00, 2, 1, 1));
    imem_wait = 0;
    dmem_wait = 0;
    @(posedge clk);
    #1;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_pc", PC, RPC);
    chk("rst_instr", instr, 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_instret", instret_cnt, 32'd0);
    #2 rst_n = 1'b1;
    #1 chk("rel_req_low", {31'd0, imem_req}, 32'd0);
    run_to(1);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RPC);
    run_to(6);
    chk("fetch2_addr", imem_addr, RPC + 4);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_pc", PC, RPC);
    chk("midrst_instr", instr, 32'd0);

    // Instruction memory stalls 10 cycles
    clear_imem();
    put(RPC, addi(1, 0, 5));
    reset_dut(10, 0);
    for (int e = 1; e <= 11; e++) begin
      run_to(e);
      chk("stall_req", {31'd0, imem_req}, 32'd1);
      chk("stall_addr", imem_addr, RPC);
      chk("stall_instr", instr, 32'd0);
    end
    run_to(12);
    chk("stall_latch", instr, addi(1, 0, 5));
    chk("stall_req_drop", {31'd0, imem_req}, 32'd0);

    // Two ALU instructions, then a store exposes the chosen register
    for (int v = 0; v < 8; v++) begin
      clear_imem();
      put(RPC, vt[v].i0);
      put(RPC + 4, vt[v].i1);
      put(RPC + 8, sw(vt[v].rs, 0, 0));
      reset_dut(0, 0);
      run_to(12);
      chk({vt[v].nm, "_st_req"}, {30'd0, dmem_req, dmem_we}, 32'd3);
      chk({vt[v].nm, "_rv32i"}, dmem_wdata, vt[v].e32);
      chk({vt[v].nm, "_rv32e"}, dmem_wdata16, vt[v].e16);
    end

    // Store then load with 3 data-memory wait cycles each
    clear_imem();
    put(RPC, addi(1, 0, 5));
    put(RPC + 4, rtype(7'h00, 2, 1, 1));
    put(RPC + 8, sw(2, 0, 0));
    put(RPC + 12, lw(3, 0, 0));
    put(RPC + 16, sw(3, 0, 4));
    reset_dut(0, 3);
    run_to(9);
`ifdef PERF_COUNTERS_EN
    chk("instret_at9", instret_cnt, 32'd2);
`else
    chk("instret_off", instret_cnt, 32'd0);
`endif
    for (int e = 10; e <= 27; e++) begin
      run_to(e);
      if (e >= 12 && e <= 15) begin
        chk("st_hold_req", {30'd0, dmem_req, dmem_we}, 32'd3);
        chk("st_hold_addr", dmem_addr, 32'd0);
        chk("st_hold_wdata", dmem_wdata, 32'd10);
      end else if (e >= 19 && e <= 22) begin
        chk("ld_req", {30'd0, dmem_req, dmem_we}, 32'd2);
        chk("ld_addr", dmem_addr, 32'd0);
      end else if (e == 27) begin
        chk("st2_req", {30'd0, dmem_req, dmem_we}, 32'd3);
        chk("st2_addr", dmem_addr, 32'd4);
        chk("st2_loaded", dmem_wdata, 32'd10);
      end else if (e >= 12) begin
        chk("dreq_idle", {31'd0, dmem_req}, 32'd0);
      end
    end
`ifdef PERF_COUNTERS_EN
    chk("cycle_at27", cycle_cnt, 32'd27);
    chk("instret_at27", instret_cnt, 32'd4);
`else
    chk("cycle_off", cycle_cnt, 32'd0);
`endif

    // Branches: jump to 32'h20, taken BEQ with imm -8, then a not-taken BEQ
    clear_imem();
    put(RPC, addi(1, 0, 5));
    put(RPC + 4, addi(2, 0, 10));
    put(RPC + 8, beq(0, 0, -232));
    put(32'h20, beq(1, 1, -8));
    put(32'h18, beq(1, 2, -8));
    reset_dut(0, 0);
    run_to(12);
    chk("br_far_pc", PC, 32'h20);
    chk("br_far_req", {31'd0, imem_req}, 32'd1);
    chk("br_far_addr", imem_addr, 32'h20);
    run_to(13);
    chk("br_t_instr", instr, beq(1, 1, -8));
    chk("br_t_pc_hold", PC, 32'h20);
    run_to(15);
    chk("br_taken_pc", PC, 32'h18);
    run_to(18);
    chk("br_nt_pc", PC, 32'h1C);
`ifdef PERF_COUNTERS_EN
    chk("br_cycle", cycle_cnt, 32'd18);
    chk("br_instret", instret_cnt, 32'd5);
`endif
    run_to(21);
    chk("br_spin_pc", PC, 32'h1C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
